// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file for the pipelined MIPS datapath with a busy-bit scoreboard.
// Issue reserves a destination register (sets its busy bit). Writeback stores
// the result and releases the reservation. The hazard unit reads the busy flags
// of the two source operands to detect RAW dependencies. It also reads the
// registered count of outstanding reservations.
//
// Parameters:
//   DATA_WIDTH - width of each register (default 32)
//   ADDR_WIDTH - register address width; depth = 2**ADDR_WIDTH (default 5)
//   ZERO_REG   - 1: register 0 reads 0, drops writes and is never busy
//
// Ports:
//   clk        in   clock, state updates on rising edge
//   rst_n      in   asynchronous active-low reset
//   ra1, ra2   in   read addresses
//   rd1, rd2   out  read data (combinational)
//   busy1/2    out  busy flag of ra1/ra2 (combinational)
//   we         in   writeback strobe
//   wa, wd     in   writeback address / data
//   rsv        in   reserve request from issue
//   rsv_addr   in   destination register to reserve
//   rsv_ready  out  reservation accepted this cycle (combinational)
//   pending    out  number of busy registers (registered)
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, a same-cycle writeback is forwarded to
//                       the read ports (data = wd, busy = 0). When not defined,
//                       the read ports reflect stored state only.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] ra1,
    input  logic [ADDR_WIDTH-1:0] ra2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    output logic                  busy1,
    output logic                  busy2,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wa,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  rsv,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic                  rsv_ready,
    output logic [ADDR_WIDTH:0]   pending
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [ADDR_WIDTH:0]   r_pending;

    // -------------------------------------------------------------------------
    // Write / reserve qualification
    // -------------------------------------------------------------------------
    logic w_wa_is_zero;
    logic w_rsv_is_zero;
    logic w_wr_en;
    logic w_rsv_hit_wr;
    logic w_rsv_ready;
    logic w_rsv_acc;
    logic w_pend_inc;
    logic w_pend_dec;

    // The zero register is special only when ZERO_REG is set.
    assign w_wa_is_zero  = ZERO_REG && (wa == '0);
    assign w_rsv_is_zero = ZERO_REG && (rsv_addr == '0);

    // Effective write: writes to the hard-wired zero register are dropped.
    assign w_wr_en      = we && !w_wa_is_zero;
    assign w_rsv_hit_wr = we && (wa == rsv_addr);

    // A busy register can still be reserved if the pending write releases it
    // this very cycle. The zero register is always reservable because the
    // reservation is a no-op.
    assign w_rsv_ready = w_rsv_is_zero || !r_busy[rsv_addr] || w_rsv_hit_wr;
    assign rsv_ready   = w_rsv_ready;

    // Only reservations that really touch the busy vector count.
    assign w_rsv_acc = rsv && w_rsv_ready && !w_rsv_is_zero;

    // The pending counter tracks the population count of r_busy exactly.
    // A reserve counts only when it sets a clear bit. A write counts only when
    // it clears a set bit. It does not count when a reserve to the same
    // address re-sets that bit on this edge. So a write and a reserve to the
    // same busy register leave the count unchanged.
    assign w_pend_inc = w_rsv_acc && !r_busy[rsv_addr];
    assign w_pend_dec = w_wr_en && r_busy[wa] &&
                        !(w_rsv_acc && (rsv_addr == wa));

    // -------------------------------------------------------------------------
    // Register array
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[wa] <= wd;
        end
    end

    // -------------------------------------------------------------------------
    // Busy vector: the release is applied first and the reserve second, so a
    // same-address reserve overrides the release and the bit ends set.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr_en) begin
                r_busy[wa] <= 1'b0;
            end
            if (w_rsv_acc) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending counter. The increment and decrement conditions are tied to real
    // bit transitions, so the value stays within 0..DEPTH without saturation.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            case ({w_pend_inc, w_pend_dec})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    assign pending = r_pending;

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic                  w_busy1;
    logic                  w_busy2;

    always_comb begin
        w_rd1   = r_mem[ra1];
        w_busy1 = r_busy[ra1];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight writeback. A same-cycle reserve does not mask
        // this because the reservation only lands after the edge.
        if (w_wr_en && (wa == ra1)) begin
            w_rd1   = wd;
            w_busy1 = 1'b0;
        end
`endif
        if (ZERO_REG && (ra1 == '0)) begin
            w_rd1   = '0;
            w_busy1 = 1'b0;
        end
    end

    always_comb begin
        w_rd2   = r_mem[ra2];
        w_busy2 = r_busy[ra2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (wa == ra2)) begin
            w_rd2   = wd;
            w_busy2 = 1'b0;
        end
`endif
        if (ZERO_REG && (ra2 == '0)) begin
            w_rd2   = '0;
            w_busy2 = 1'b0;
        end
    end

    assign rd1   = w_rd1;
    assign rd2   = w_rd2;
    assign busy1 = w_busy1;
    assign busy2 = w_busy2;

endmodule
